// File: rtl/cla_pkg.sv
// Shared sizing constants for the two-level carry-lookahead adder.
package cla_pkg;
    localparam int CLA_WIDTH   = 16;
    localparam int CLA_GROUP   = 4;
    localparam int CLA_NGROUPS = CLA_WIDTH / CLA_GROUP;
endpackage

// File: rtl/cla_4_bit_slice.sv
// 4-bit carry-lookahead slice: flat lookahead carries, sum bits and group G/P terms.
module cla_4_bit_slice
    import cla_pkg::*;
(
    input  logic [CLA_GROUP-1:0] a,
    input  logic [CLA_GROUP-1:0] b,
    input  logic                 c0,
    output logic [CLA_GROUP-1:0] s,
    output logic                 g,
    output logic                 p
);
    logic [CLA_GROUP-1:0] gen;
    logic [CLA_GROUP-1:0] prop;
    logic [CLA_GROUP-1:0] c;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Every carry is a two-level sum of products from c0; nothing ripples.
    assign c[0] = c0;
    assign c[1] = gen[0] | (prop[0] & c0);
    assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & c0);
    assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                | (prop[2] & prop[1] & prop[0] & c0);

    assign s = prop ^ c;

    assign g = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0]);
    assign p = &prop;
endmodule

// File: rtl/cla_16_bit_adder.sv
// 16-bit two-level carry-lookahead adder with a single registered output stage.
module cla_16_bit_adder
    import cla_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CLA_WIDTH-1:0] a,
    input  logic [CLA_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [CLA_WIDTH-1:0] sum,
    output logic                 cout
);
    logic [CLA_NGROUPS-1:0] grp_g;
    logic [CLA_NGROUPS-1:0] grp_p;
    logic [CLA_NGROUPS:0]   grp_c;
    logic [CLA_WIDTH-1:0]   sum_c;

    genvar gi;
    generate
        for (gi = 0; gi < CLA_NGROUPS; gi++) begin : g_slice
            cla_4_bit_slice u_slice (
                .a  (a[gi*CLA_GROUP +: CLA_GROUP]),
                .b  (b[gi*CLA_GROUP +: CLA_GROUP]),
                .c0 (grp_c[gi]),
                .s  (sum_c[gi*CLA_GROUP +: CLA_GROUP]),
                .g  (grp_g[gi]),
                .p  (grp_p[gi])
            );
        end
    endgenerate

    // Second-level lookahead: slice carries come straight from G/P and cin.
    assign grp_c[0] = cin;
    assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
    assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
    assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
    assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= sum_c;
            cout <= grp_c[CLA_NGROUPS];
        end
    end
endmodule

// File: tb/tb_cla_16_bit_adder.sv
// Scoreboard bench for cla_16_bit_adder: stimulus queues expected {cout,sum}, monitor checks one clk later.
module tb_cla_16_bit_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = 16'h1234;
    logic [15:0] b = 16'h1111;
    logic        cin = 1'b0;
    logic [15:0] sum;
    logic        cout;

    logic [16:0] exp_q[$];
    int total = 0;
    int bad = 0;

    cla_16_bit_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [16:0] got, input logic [16:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got cout=%0b sum=%h, want cout=%0b sum=%h",
                     name, got[16], got[15:0], want[16], want[15:0]);
        end else begin
            $display("ok   %s: cout=%0b sum=%h", name, got[16], got[15:0]);
        end
    endtask

    task automatic apply(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                         input logic [16:0] want);
        a = va;
        b = vb;
        cin = vc;
        exp_q.push_back(want);
    endtask

    task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                         input logic [16:0] want);
        @(negedge clk);
        apply(va, vb, vc, want);
    endtask

    // Monitor: the adder presents a fresh result after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                logic [16:0] want;
                want = exp_q.pop_front();
                check("pipe", {cout, sum}, want);
            end
        end
    end

    initial begin
        logic [15:0] va;
        logic [15:0] vb;
        logic [16:0] want;
        int waited;

        // Reset held across clocks with live inputs.
        repeat (2) @(posedge clk);
        #1 check("reset_hold", {cout, sum}, 17'h0);
        @(negedge clk);
        check("reset_hold_neg", {cout, sum}, 17'h0);
        rst_n = 1'b1;
        apply(16'h1234, 16'h1111, 1'b0, {1'b0, 16'h2345});

        drive(16'hFFFF, 16'h0001, 1'b0, {1'b1, 16'h0000});
        drive(16'hFFFF, 16'h0000, 1'b1, {1'b1, 16'h0000});
        drive(16'h0F0F, 16'hF0F0, 1'b0, {1'b0, 16'hFFFF});
        drive(16'h0F0F, 16'hF0F0, 1'b1, {1'b1, 16'h0000});
        drive(16'hFFFF, 16'hFFFF, 1'b1, {1'b1, 16'hFFFF});
        drive(16'h8000, 16'h8000, 1'b0, {1'b1, 16'h0000});
        drive(16'h7FFF, 16'h0001, 1'b0, {1'b0, 16'h8000});

        // Sweep over multiples of 3855 (0x0F0F), 18 values per operand.
        for (int ci = 0; ci < 2; ci++) begin
            for (int i = 0; i < 18; i++) begin
                for (int j = 0; j < 18; j++) begin
                    va = 16'(i * 3855);
                    vb = 16'(j * 3855);
                    want = {1'b0, va} + {1'b0, vb} + 17'(ci);
                    drive(va, vb, ci[0], want);
                end
            end
        end

        // Mid-operation reset: the pending AAAA+5555 result must never appear.
        drive(16'h0100, 16'h0200, 1'b0, {1'b0, 16'h0300});
        @(negedge clk);
        a = 16'hAAAA;
        b = 16'h5555;
        cin = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("async_reset", {cout, sum}, 17'h0);
        @(posedge clk);
        #1 check("reset_over_edge", {cout, sum}, 17'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(16'h0003, 16'h0004, 1'b1, {1'b0, 16'h0008});
        drive(16'h4000, 16'hC000, 1'b0, {1'b1, 16'h0000});

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d results pending, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cla_16_bit_adder.md
Name: cla_16_bit_adder

Overview:
- 16-bit carry-lookahead adder: sum = a + b + cin, with carry-out.
- Two-level lookahead: four 4-bit CLA slices feed a second-level lookahead carry unit. No ripple between slices.
- Result is captured in a single output register stage.
- Serves as the add datapath primitive for the ALU in the KGP-RISC core.

Parameters:
- WIDTH, 16, operand width; fixed at 16 (other values unsupported).
- GROUP, 4, bits per lookahead slice; fixed at 4.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- a  input  16  operand A, unsigned/two's-complement agnostic.
- b  input  16  operand B.
- cin  input  1  carry-in.
- sum  output  16  registered (a + b + cin) mod 2^16.
- cout  output  1  registered carry-out, bit 16 of a + b + cin.

Behaviour:
- Bit level: g[i] = a[i] & b[i] and p[i] = a[i] ^ b[i].
- Slice k (bits 4k..4k+3), carries:
  - c1 = g0 | p0·c0.
  - c2 = g1 | p1·g0 | p1·p0·c0.
  - c3 follows the same lookahead pattern.
  - No carry chains inside a slice.
- Slice group terms:
  - Gk = g3 | p3g2 | p3p2g1 | p3p2p1g0.
  - Pk = p3p2p1p0.
- Second-level carries:
  - C4 = G0 | P0·cin.
  - C8 = G1 | P1G0 | P1P0cin.
  - C12 follows the same pattern.
  - C16 = G3 | P3G2 | P3P2G1 | P3P2P1G0 | P3P2P1P0cin.
- Combinational results: sum_c[i] = p[i] ^ c[i]; cout_c = C16.
- Register stage:
  - On each rising clk: sum <= sum_c and cout <= cout_c.
  - Latency is 1 cycle; throughput is 1 result per cycle.
  - No enable and no handshake; inputs are sampled every cycle.
- Reset:
  - rst_n low forces sum = 16'h0000 and cout = 0 immediately, independent of clk.
  - Outputs stay there while rst_n is low.
  - The first rising clk after rst_n deasserts captures the current inputs.
  - Reset mid-operation discards the pending result; no residual state.
- Arithmetic boundaries:
  - Wrap-around is modulo 2^16, with overflow reported only through cout.
  - No signed overflow flag.
  - Max case 16'hFFFF + 16'hFFFF + 1 gives sum 16'hFFFF, cout 1.
  - Propagate-through case a = 16'hFFFF, b = 0, cin = 1 gives sum 0, cout 1; the carry is resolved through all-P lookahead.
- No X propagation beyond inputs; no latches; all combinational logic is fully assigned.

Decomposition:
- Shared package (cla_pkg):
  - CLA_WIDTH = 16.
  - CLA_GROUP = 4.
  - CLA_NGROUPS = 4.
- Sub-module cla_4_bit_slice:
  - Inputs: a[3:0], b[3:0], c0.
  - Outputs: s[3:0], G, P.
  - Instantiated 4 times.
- Top-level logic: the second-level lookahead carry equations and the output register.

Test Plan:
- rst_n = 0 with a = 16'h1234, b = 16'h1111 applied -> sum = 0, cout = 0 regardless of clk. Deassert, one clk -> sum = 16'h2345, cout = 0.
- a = 16'hFFFF, b = 16'h0001, cin = 0 -> after 1 clk sum = 16'h0000, cout = 1. Same a, b = 0, cin = 1 -> sum = 0, cout = 1.
- a = 16'h0F0F, b = 16'hF0F0:
  - cin = 0 -> sum = 16'hFFFF, cout = 0.
  - cin = 1 -> sum = 16'h0000, cout = 1.
- Sweep a, b over multiples of 3855 (0, 16'h0F0F, … 16'hFFFF; 18 values each) for cin = 0 and cin = 1. Per cycle, check {cout, sum} = a + b + cin one clk later (648 checks). Example: 16'hFFFF + 16'hFFFF + 1 -> 16'hFFFF, cout 1.
- Back-to-back inputs changing every cycle (16'h8000 + 16'h8000, then 16'h7FFF + 16'h0001) -> outputs show cout 1/sum 0, then cout 0/sum 16'h8000 on consecutive cycles.
- Assert rst_n between two valid cycles -> outputs drop to 0 asynchronously. Next post-reset clk shows only the newly applied inputs' result.
